// File: rtl/prog_clk_div.sv
// prog_clk_div - runtime-programmable integer clock divider.
//
// Divides clk by any ratio N in 2..2^WIDTH-1 (odd or even). The output is
// high for ceil(N/2) cycles and low for floor(N/2) cycles. A new ratio is
// staged in a pending register and is only adopted at the end of a full
// output period, so every period is exactly N_act enabled cycles long.
//
// Parameters
//   WIDTH        width of the ratio field and of the period counter
//   DEFAULT_DIV  ratio active after reset (2..2^WIDTH-1)
//
// Ports
//   clk        in   system clock, rising edge only
//   rst        in   synchronous active-high reset
//   en         in   count enable; low freezes counter and clk_out
//   div_val    in   requested divide ratio
//   div_load   in   one-cycle strobe capturing div_val
//   clk_out    out  divided clock (registered)
//   tick       out  one-cycle pulse on the cycle clk_out rises (registered)
//   load_pend  out  a captured ratio is waiting for the next wrap
//   load_err   out  one-cycle pulse when a ratio below 2 is rejected
module prog_clk_div #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             load_pend,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] DEF_N    = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_TERM = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             load_pend_q, load_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             load_err_q, load_err_d;

  logic             at_term;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   high_len;
  logic             val_ok;

  always_comb begin
    count_d     = count_q;
    n_act_d     = n_act_q;
    pending_d   = pending_q;
    load_pend_d = load_pend_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    load_err_d  = 1'b0;

    at_term = (count_q == (n_act_q - WIDTH'(1)));
    nxt     = at_term ? '0 : (count_q + WIDTH'(1));
    val_ok  = (div_val >= WIDTH'(2));

    // The wrap consumes the pending state as it stood before this edge;
    // a load on the same edge is handled below and lands in pending.
    if (en) begin
      if (at_term && load_pend_q) begin
        n_act_d     = pending_q;
        load_pend_d = 1'b0;
      end
      count_d = nxt;
    end

    // High time from the ratio in force for nxt; one extra bit keeps
    // N = 2^WIDTH-1 from overflowing the +1.
    high_len = ({1'b0, n_act_d} + (WIDTH+1)'(1)) >> 1;

    if (en) begin
      clk_out_d = ({1'b0, nxt} < high_len);
      tick_d    = (nxt == '0);
    end

    if (div_load) begin
      if (val_ok) begin
        pending_d   = div_val;
        load_pend_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= DEF_TERM;
      n_act_q     <= DEF_N;
      pending_q   <= '0;
      load_pend_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      n_act_q     <= n_act_d;
      pending_q   <= pending_d;
      load_pend_q <= load_pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      load_err_q  <= load_err_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign load_pend = load_pend_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_clk_div.sv
module tb_prog_clk_div;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_load;
  logic [WIDTH-1:0] div_val;
  logic             clk_out;
  logic             tick;
  logic             load_pend;
  logic             load_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit r;
    bit e;
    bit ld;
    int v;
  } stim_t;

  stim_t      stim_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] exp_w;
  stim_t      s;

  prog_clk_div #(.WIDTH(WIDTH), .DEFAULT_DIV(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .load_pend(load_pend),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  // Expected {clk_out, tick, load_pend, load_err} at position p of an
  // N-cycle period: high for the first ceil(N/2) positions, tick at 0.
  function automatic logic [3:0] ew(int n, int p, bit pend, bit err);
    logic hi, tk;
    hi = (p < (n + 1) / 2);
    tk = (p == 0);
    return {hi, tk, pend, err};
  endfunction

  task automatic cyc(input bit r, input bit e, input bit ld, input int v);
    logic [31:0] vv;
    vv       = v;
    rst      = r;
    en       = e;
    div_load = ld;
    div_val  = vv[WIDTH-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit r, input bit e, input bit ld, input int v, input logic [3:0] x);
    stim_t t;
    t.r = r; t.e = e; t.ld = ld; t.v = v;
    stim_q.push_back(t);
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    int k = 0;
    add(1, 0, 0, 0, 4'b0000);
    add(1, 1, 1, 7, 4'b0000);   // reset beats en and a load
    add(1, 1, 1, 0, 4'b0000);   // and beats a rejected load
    add(0, 0, 0, 0, 4'b0000);   // released, disabled: everything holds
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL reset step %0d: got clk/tick/pend/err=%b expected %b",
                 k, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  task automatic test_default();
    int k = 0;
    for (int per = 0; per < 3; per++)
      for (int p = 0; p < 16; p++) add(0, 1, 0, 0, ew(16, p, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL default_div16 cycle %0d: got clk/tick/pend/err=%b expected %b",
                 k + 1, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  task automatic test_load();
    int k = 0;
    for (int p = 0; p < 4; p++) add(0, 1, 0, 0, ew(16, p, 0, 0));
    add(0, 1, 1, 5, ew(16, 4, 1, 0));
    for (int p = 5; p < 16; p++) add(0, 1, 0, 0, ew(16, p, 1, 0));
    for (int per = 0; per < 3; per++)
      for (int p = 0; p < 5; p++) add(0, 1, 0, 0, ew(5, p, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL load_div5 step %0d: got clk/tick/pend/err=%b expected %b",
                 k, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  task automatic test_load_err();
    int k = 0;
    add(0, 1, 1, 1, ew(5, 0, 0, 1));
    add(0, 1, 1, 0, ew(5, 1, 0, 1));
    for (int p = 2; p < 5; p++) add(0, 1, 0, 0, ew(5, p, 0, 0));
    add(0, 0, 1, 0, 4'b0001);   // rejection reported while disabled too
    for (int p = 0; p < 5; p++) add(0, 1, 0, 0, ew(5, p, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL load_err step %0d: got clk/tick/pend/err=%b expected %b",
                 k, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    add(0, 1, 1, 7, ew(5, 0, 1, 0));   // load on a wrap edge: ratio 5 kept
    add(0, 1, 1, 9, ew(5, 1, 1, 0));   // overwrites 7
    for (int p = 2; p < 5; p++) add(0, 1, 0, 0, ew(5, p, 1, 0));
    for (int per = 0; per < 2; per++)
      for (int p = 0; p < 9; p++) add(0, 1, 0, 0, ew(9, p, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL back_to_back step %0d: got clk/tick/pend/err=%b expected %b",
                 k, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  task automatic test_enable();
    int k = 0;
    add(0, 1, 1, 10, ew(9, 0, 1, 0));
    for (int p = 1; p < 9; p++) add(0, 1, 0, 0, ew(9, p, 1, 0));
    for (int p = 0; p < 6; p++) add(0, 1, 0, 0, ew(10, p, 0, 0));
    // frozen at count=5 (low phase) for 4 cycles; a load lands meanwhile
    add(0, 0, 0, 0, 4'b0000);
    add(0, 0, 1, 4, 4'b0010);
    add(0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 0, 4'b0010);
    for (int p = 6; p < 10; p++) add(0, 1, 0, 0, ew(10, p, 1, 0));
    for (int per = 0; per < 2; per++)
      for (int p = 0; p < 4; p++) add(0, 1, 0, 0, ew(4, p, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL enable_freeze step %0d: got clk/tick/pend/err=%b expected %b",
                 k, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    add(0, 1, 1, 12, ew(4, 0, 1, 0));
    add(1, 1, 0, 0, 4'b0000);
    add(0, 0, 0, 0, 4'b0000);
    for (int p = 0; p < 16; p++) add(0, 1, 0, 0, ew(16, p, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL reset_mid step %0d: got clk/tick/pend/err=%b expected %b",
                 k, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  task automatic test_max();
    int k = 0;
    add(0, 1, 1, 255, ew(16, 0, 1, 0));
    for (int p = 1; p < 16; p++) add(0, 1, 0, 0, ew(16, p, 1, 0));
    for (int p = 0; p < 255; p++) add(0, 1, 0, 0, ew(255, p, 0, 0));
    add(0, 1, 0, 0, ew(255, 0, 0, 0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      cyc(s.r, s.e, s.ld, s.v);
      exp_w = exp_q.pop_front();
      n_cmp++;
      if ({clk_out, tick, load_pend, load_err} !== exp_w) begin
        n_err++;
        $display("FAIL max_div255 step %0d: got clk/tick/pend/err=%b expected %b",
                 k, {clk_out, tick, load_pend, load_err}, exp_w);
      end
      k++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    test_reset();
    test_default();
    test_load();
    test_load_err();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
